// File: rtl/posit_pkg.sv
// posit_pkg: types shared by the posit PPU output path.
//   status_t        - fflags-style status word {nv, dz, of, uf, nx}
//   collect_entry_t - one buffered result {result, status, ext_bit}. The tag
//                     is stored beside it because its type is a parameter.
//   idx_width()     - width of an index into n items, never below one bit
package posit_pkg;

  localparam int unsigned POSIT_WIDTH = 32;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef struct packed {
    logic [POSIT_WIDTH-1:0] result;
    status_t                status;
    logic                   ext_bit;
  } collect_entry_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/posit_rr_arbiter.sv
// posit_rr_arbiter: combinational round-robin pick among NumSlices requests.
// The search starts at rr_i and moves upward, wrapping around.
//   req_i     in  NumSlices  request vector
//   rr_i      in  IdxW       search start (round-robin pointer)
//   gnt_o     out NumSlices  one-hot grant, zero when nothing is requested
//   gnt_idx_o out IdxW       index of the granted request (0 when none)
module posit_rr_arbiter
  import posit_pkg::*;
#(
  parameter int unsigned NumSlices = 3,
  localparam int unsigned IdxW = idx_width(NumSlices)
) (
  input  logic [NumSlices-1:0] req_i,
  input  logic [IdxW-1:0]      rr_i,
  output logic [NumSlices-1:0] gnt_o,
  output logic [IdxW-1:0]      gnt_idx_o
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned off = 0; off < NumSlices; off++) begin
      // rr_i + off is below 2*NumSlices, so one conditional subtract is the modulo.
      sum = {1'b0, rr_i} + (IdxW + 1)'(off);
      if (sum >= (IdxW + 1)'(NumSlices)) begin
        sum = sum - (IdxW + 1)'(NumSlices);
      end
      idx = sum[IdxW-1:0];
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/posit_result_collector.sv
// posit_result_collector: collects results from the per-opgroup slices.
// Slice outputs are arbitrated round-robin. The granted result goes into a
// small FIFO, and the FIFO head is handed to writeback over valid/ready.
//
// Optional feature macro: POSIT_STICKY_STATUS_EN
//   defined   - sticky_status_o ORs in the status of every popped entry;
//               clear_status_i zeroes it and wins over a same-cycle pop
//   undefined - sticky_status_o is 0 and clear_status_i is ignored
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   slv_result_i/status_i/ext_bit_i/tag_i/valid_i   slice outputs
//   slv_ready_o           one-hot grant back to the slices
//   slv_busy_i            slice busy flags, folded into busy_o
//   flush_i               drop all buffered results
//   result_o/status_o/extension_bit_o/tag_o/out_valid_o   FIFO head
//   out_ready_i           writeback accepts the head
//   busy_o                any slice busy, or the FIFO is not empty
//   clear_status_i        clear the sticky status
//   sticky_status_o       accumulated status
module posit_result_collector
  import posit_pkg::*;
#(
  parameter int unsigned NumSlices = 3,
  parameter int unsigned Width     = 32,
  parameter int unsigned Depth     = 2,
  parameter type         TagType   = logic
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumSlices-1:0][Width-1:0] slv_result_i,
  input  status_t [NumSlices-1:0]         slv_status_i,
  input  logic [NumSlices-1:0]            slv_ext_bit_i,
  input  TagType                          slv_tag_i [NumSlices],
  input  logic [NumSlices-1:0]            slv_valid_i,
  output logic [NumSlices-1:0]            slv_ready_o,
  input  logic [NumSlices-1:0]            slv_busy_i,
  input  logic                            flush_i,
  output logic [Width-1:0]                result_o,
  output status_t                         status_o,
  output logic                            extension_bit_o,
  output TagType                          tag_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            busy_o,
  input  logic                            clear_status_i,
  output status_t                         sticky_status_o
);

  localparam int unsigned IdxW = idx_width(NumSlices);
  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  // Each entry stores its result in a POSIT_WIDTH field, so a wider slice result would be cut.
  if (Width > POSIT_WIDTH) begin : g_width_check
    $error("posit_result_collector: Width exceeds posit_pkg::POSIT_WIDTH");
  end

  logic [IdxW-1:0] rr_q, rr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  collect_entry_t  entry_q [Depth];
  collect_entry_t  entry_d [Depth];
  TagType          tag_q [Depth];
  TagType          tag_d [Depth];

  logic [NumSlices-1:0] arb_gnt;
  logic [IdxW-1:0]      arb_idx;
  logic                 can_push;
  logic                 push;
  logic                 pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    if (Depth == 1) return '0;
    return p + 1'b1;
  endfunction

  posit_rr_arbiter #(
    .NumSlices (NumSlices)
  ) u_arb (
    .req_i     (slv_valid_i),
    .rr_i      (rr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  // A full FIFO can still take an entry when the head leaves in the same cycle.
  assign can_push    = (count_q < CntW'(Depth)) | pop;
  // Gate on rst_i so no slice sees a grant while the collector is held in reset.
  assign push        = (|arb_gnt) & can_push & ~flush_i & ~rst_i;
  assign slv_ready_o = push ? arb_gnt : '0;
  assign busy_o      = (|slv_busy_i) | out_valid_o;

  always_comb begin
    rr_d     = rr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    entry_d  = entry_q;
    tag_d    = tag_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        entry_d[wr_ptr_q] = '{result:  POSIT_WIDTH'(slv_result_i[arb_idx]),
                              status:  slv_status_i[arb_idx],
                              ext_bit: slv_ext_bit_i[arb_idx]};
        tag_d[wr_ptr_q]   = slv_tag_i[arb_idx];
        wr_ptr_d          = next_ptr(wr_ptr_q);
        rr_d              = (arb_idx == IdxW'(NumSlices - 1)) ? '0 : arb_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        entry_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      rr_q     <= rr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      entry_q  <= entry_d;
      tag_q    <= tag_d;
    end
  end

  // When empty the outputs show a neutral entry, with the extension bit set.
  always_comb begin
    result_o        = '0;
    status_o        = '0;
    extension_bit_o = 1'b1;
    tag_o           = '0;
    if (out_valid_o) begin
      result_o        = Width'(entry_q[rd_ptr_q].result);
      status_o        = entry_q[rd_ptr_q].status;
      extension_bit_o = entry_q[rd_ptr_q].ext_bit;
      tag_o           = tag_q[rd_ptr_q];
    end
  end

`ifdef POSIT_STICKY_STATUS_EN
  status_t sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (clear_status_i) begin
      sticky_d = '0;
    end else if (pop) begin
      sticky_d = sticky_q | status_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_status_o = sticky_q;
`else
  logic unused_clear_status;
  assign unused_clear_status = clear_status_i;
  assign sticky_status_o     = '0;
`endif

endmodule

// File: tb/tb_posit_result_collector.sv
// Bench for posit_result_collector. A negedge model predicts the grant and
// the FIFO fill level. A scoreboard queue takes each granted entry and
// compares it with the FIFO head when that head is popped.
module tb_posit_result_collector;
  import posit_pkg::*;

  localparam int NS = 3;
  localparam int W  = 32;
  localparam int D  = 2;
  localparam int IW = 2;

  typedef struct {
    logic [W-1:0] result;
    status_t      status;
    logic         ext;
    logic         tag;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NS-1:0][W-1:0] slv_result;
  status_t [NS-1:0]     slv_status;
  logic [NS-1:0]        slv_ext;
  logic                 slv_tag [NS];
  logic [NS-1:0]        slv_valid;
  logic [NS-1:0]        slv_ready;
  logic [NS-1:0]        slv_busy;
  logic                 flush;
  logic [W-1:0]         result;
  status_t              status;
  logic                 ext;
  logic                 tag;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 clear;
  status_t              sticky;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   m_count = 0;
  int   m_rr = 0;
  status_t m_sticky = '0;
  status_t st_nx, st_of, st_exp;

  posit_result_collector #(
    .NumSlices (NS),
    .Width     (W),
    .Depth     (D),
    .TagType   (logic)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .slv_result_i    (slv_result),
    .slv_status_i    (slv_status),
    .slv_ext_bit_i   (slv_ext),
    .slv_tag_i       (slv_tag),
    .slv_valid_i     (slv_valid),
    .slv_ready_o     (slv_ready),
    .slv_busy_i      (slv_busy),
    .flush_i         (flush),
    .result_o        (result),
    .status_o        (status),
    .extension_bit_o (ext),
    .tag_o           (tag),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .busy_o          (busy),
    .clear_status_i  (clear),
    .sticky_status_o (sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model, evaluated on the falling edge while inputs are stable.
  always @(negedge clk) begin
    logic [NS-1:0] eg;
    logic          m_pop;
    int            gi;
    int            j;
    exp_t          e;
    if (rst) begin
      m_count  = 0;
      m_rr     = 0;
      m_sticky = '0;
      sb.delete();
    end else begin
      m_pop = (m_count != 0) && out_ready;
      eg    = '0;
      gi    = -1;
      if (!flush && (m_count < D || m_pop)) begin
        for (int k = 0; k < NS; k++) begin
          j = (m_rr + k) % NS;
          if (gi < 0 && slv_valid[IW'(j)]) gi = j;
        end
      end
      if (gi >= 0) eg = 3'b001 << gi;
      check("gnt", slv_ready, eg);
      check("out_valid", out_valid, m_count != 0);
      check("busy", busy, (|slv_busy) || (m_count != 0));
      check("sticky", sticky, m_sticky);
      if (m_count == 0) begin
        check("empty_out", {result, status, ext, tag}, {32'h0, 5'h0, 1'b1, 1'b0});
      end
      if (m_pop) begin
        e = sb.pop_front();
        check("head", {result, status, ext, tag}, {e.result, e.status, e.ext, e.tag});
      end
`ifdef POSIT_STICKY_STATUS_EN
      if (clear) m_sticky = '0;
      else if (m_pop) m_sticky = m_sticky | e.status;
`endif
      if (flush) begin
        sb.delete();
        m_count = 0;
      end else begin
        if (gi >= 0) begin
          sb.push_back('{slv_result[IW'(gi)], slv_status[IW'(gi)],
                         slv_ext[IW'(gi)], slv_tag[gi]});
          m_rr = (gi + 1) % NS;
          m_count++;
        end
        if (m_pop) m_count--;
      end
    end
  end

  task automatic rand_data();
    for (int i = 0; i < NS; i++) begin
      slv_result[i] = $urandom;
      slv_status[i] = 5'($urandom);
      slv_ext[i]    = 1'($urandom);
      slv_tag[i]    = 1'($urandom);
    end
  endtask

  initial begin
    st_nx = '0; st_nx.nx = 1'b1;
    st_of = '0; st_of.of = 1'b1;
    slv_result = '0; slv_status = '0; slv_ext = '0;
    for (int i = 0; i < NS; i++) slv_tag[i] = 1'b0;
    slv_valid = '1; slv_busy = 3'b100;
    flush = 1'b0; out_ready = 1'b0; clear = 1'b0;

    // Reset state, with every slice requesting.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_ready", slv_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_ext", ext, 1);
    check("rst_sticky", sticky, 0);
    slv_busy = '0;
    #1;
    check("rst_busy_idle", busy, 0);
    rst = 1'b0;
    slv_valid = '0;
    check("rst_rr", dut.rr_q, 0);

    // Single result from slice 1.
    slv_result[1] = 32'h4000_0000; slv_status[1] = '0; slv_tag[1] = 1'b1; slv_ext[1] = 1'b0;
    slv_valid = 3'b010; out_ready = 1'b1;
    @(negedge clk);
    check("t1_gnt", slv_ready, 3'b010);
    cyc();
    slv_valid = '0;
    check("t1_valid", out_valid, 1);
    check("t1_result", result, 32'h4000_0000);
    check("t1_tag", tag, 1);
    check("t1_rr", dut.rr_q, 2);
    cyc();
    check("t1_drained", out_valid, 0);

    // Fairness: the grant order is 0,1,2,0,1,2 starting from a fresh reset.
    rst = 1'b1; cyc(); rst = 1'b0;
    slv_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_data();
      @(negedge clk);
      check("fair_gnt", slv_ready, 3'b001 << (k % 3));
      cyc();
    end
    slv_valid = '0;
    repeat (3) cyc();

    // Backpressure.
    slv_valid = 3'b001; out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_data();
      @(negedge clk);
      check("bp_gnt", slv_ready, 3'b001);
      cyc();
    end
    @(negedge clk);
    check("bp_full_gnt", slv_ready, 0);
    check("bp_full_count", dut.count_q, 2);
    cyc();
    out_ready = 1'b1; rand_data();
    @(negedge clk);
    check("bp_pp_gnt", slv_ready, 3'b001);
    cyc();
    check("bp_pp_count", dut.count_q, 2);
    out_ready = 1'b0;

    // Flush with two entries held and slice 0 valid.
    flush = 1'b1;
    @(negedge clk);
    check("fl_gnt", slv_ready, 0);
    cyc();
    flush = 1'b0; slv_valid = '0;
    check("fl_valid", out_valid, 0);
    check("fl_count", dut.count_q, 0);

    // Reset in the middle of the stream with the FIFO full.
    slv_valid = 3'b010; rand_data();
    cyc(); cyc();
    check("rm_full", dut.count_q, 2);
    #2;
    rst = 1'b1;
    #1;
    check("rm_valid", out_valid, 0);
    check("rm_ready", slv_ready, 0);
    cyc();
    rst = 1'b0; slv_valid = '0;
    check("rm_rr", dut.rr_q, 0);
    check("rm_valid_after", out_valid, 0);

    // Sticky status: pop NX, then OF; then clear; then clear racing a pop.
    out_ready = 1'b1; slv_valid = 3'b001; slv_status[0] = st_nx;
    cyc();
    slv_status[0] = st_of;
    cyc();
    slv_valid = '0;
    cyc();
`ifdef POSIT_STICKY_STATUS_EN
    st_exp = st_nx | st_of;
`else
    st_exp = '0;
`endif
    check("sticky_acc", sticky, st_exp);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("sticky_clr", sticky, 0);
    slv_valid = 3'b001; slv_status[0] = st_of;
    cyc();
    slv_valid = '0; clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("sticky_clr_pop", sticky, 0);

    // Random traffic, checked by the model and the scoreboard.
    for (int k = 0; k < 80; k++) begin
      rand_data();
      slv_valid = 3'($urandom);
      slv_busy  = 3'($urandom);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 12) == 0;
      clear     = ($urandom % 9) == 0;
      cyc();
    end
    slv_valid = '0; slv_busy = '0; flush = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    check("final_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
